// File: rtl/read_port_arbiter.sv
// read_port_arbiter
// Round-robin arbiter that shares one FIFO read port among NUM_REQ requesters.
// A grant lasts for up to BURST_MAX reads. It ends early when the granted
// requester drops req or the FIFO runs empty. Every grant is followed by one
// idle cycle. Read data is returned to the granted requester one cycle after
// each read, along with a one-hot rvalid strobe.
// Optional feature: define RD_ARB_STATS_EN to add the saturating 16-bit
// rd_count output, which counts all FIFO reads since reset.
module read_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_MAX  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_read,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_req_read,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
`ifdef RD_ARB_STATS_EN
  output logic [15:0]           rd_count,
`endif
  output logic                  busy
);

  localparam int                 IDXW      = $clog2(NUM_REQ);
  localparam logic [3:0]         LAST_READ = 4'(BURST_MAX - 1);
  localparam logic [IDXW-1:0]    RST_IDX   = IDXW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
  logic [IDXW-1:0]     last_idx_q, last_idx_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic [IDXW-1:0]     sel_s;
  logic                rd_s;

  // Find the first asserted request, searching upward from last+1 and
  // wrapping past NUM_REQ-1 back to 0.
  function automatic logic [IDXW-1:0] rr_pick(input logic [IDXW-1:0] last,
                                              input logic [NUM_REQ-1:0] r);
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] ci;
    logic            found;
    int              cand;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      ci   = IDXW'(cand);
      if (!found && r[ci]) begin
        found = 1'b1;
        pick  = ci;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Next-state logic: arbitration in IDLE, read issue and burst termination in BURST.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_idx_d  = last_idx_q;
    burst_cnt_d = burst_cnt_q;
    rvalid_d    = '0;
    rd_s        = 1'b0;
    sel_s       = rr_pick(last_idx_q, req);
    case (state_q)
      IDLE: begin
        if ((|req) && !fifo_empty) begin
          state_d     = BURST;
          grant_d     = ONE_HOT0 << sel_s;
          last_idx_d  = sel_s;
          burst_cnt_d = 4'd0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      BURST: begin
        rd_s = req[last_idx_q] & ~fifo_empty;
        if (rd_s) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
          rvalid_d    = ONE_HOT0 << last_idx_q;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
        if ((rd_s && (burst_cnt_q == LAST_READ)) || !req[last_idx_q] || fifo_empty) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops any pending rvalid.
  always_ff @(posedge clk_read or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rvalid_q    <= '0;
      last_idx_q  <= RST_IDX;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rvalid_q    <= rvalid_d;
      last_idx_q  <= last_idx_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign fifo_req_read = rd_s;
  assign grant         = grant_q;
  assign rvalid        = rvalid_q;
  assign rdata         = fifo_rdata;
  assign busy          = (state_q == BURST);

`ifdef RD_ARB_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;

  // Count reads, holding at all-ones instead of wrapping.
  always_comb begin
    if (rd_s && (rd_count_q != 16'hFFFF)) begin
      rd_count_d = rd_count_q + 16'd1;
    end else begin
      rd_count_d = rd_count_q;
    end
  end

  // Read-count register.
  always_ff @(posedge clk_read or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_q <= 16'd0;
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: doc/read_port_arbiter.md
READ_PORT_ARBITER -- requirements
Module: read_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of read requesters, range 2..8.
REQ-002 SHALL have parameter BURST_MAX, default 4: maximum FIFO reads per grant, range 1..16.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
REQ-004 SHALL have port clk_read  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester read request, level, held while requester wants data.
REQ-007 SHALL have port fifo_empty  input  1  empty flag from FIFO read pointer logic.
REQ-008 SHALL have port fifo_rdata  input  DATA_WIDTH  FIFO memory read data, valid one cycle after a read.
REQ-009 SHALL have port fifo_req_read  output  1  read request to FIFO read pointer logic.
REQ-010 SHALL have port grant  output  NUM_REQ  one-hot registered grant, all zero when idle.
REQ-011 SHALL have port rvalid  output  NUM_REQ  one-hot data-valid strobe to the granted requester.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  read data, equal to fifo_rdata.
REQ-013 SHALL have port busy  output  1  high in state BURST.

Function
REQ-014 SHALL implement two states: IDLE and BURST.
REQ-015 In IDLE, when req is nonzero and fifo_empty is low, SHALL select the first asserted req in round-robin order starting at index (last_idx+1) mod NUM_REQ, load grant one-hot, store last_idx, clear burst counter, and enter BURST next cycle.
REQ-016 In IDLE, when fifo_empty is high, SHALL issue no grant, whatever req is.
REQ-017 In BURST, fifo_req_read SHALL equal req[granted] AND NOT fifo_empty, combinationally; it SHALL be 0 in IDLE.
REQ-018 Each cycle with fifo_req_read high SHALL increment the 4-bit burst counter.
REQ-019 SHALL return to IDLE, clearing grant, at the end of the cycle in which any of these holds: the read counted is number BURST_MAX; req[granted] is low; fifo_empty is high.
REQ-020 rvalid[g] SHALL assert for exactly one cycle, the cycle after each fifo_req_read pulse, g being the index granted at the read, even if grant has since cleared.
REQ-021 SHALL issue at most one grant and one read per cycle; rvalid SHALL never have more than one bit set.
REQ-022 A requester raising req during another's burst SHALL wait until IDLE; no preemption.
REQ-023 After a grant ends, SHALL keep at least one IDLE cycle before the next grant, giving one bubble cycle between bursts.
REQ-024 last_idx SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-025 On reset_n low, SHALL asynchronously force state IDLE, grant=0, rvalid=0, burst counter=0, last_idx=NUM_REQ-1 (first arbitration favours index 0), and fifo_req_read=0.
REQ-026 Reset asserted mid-burst SHALL drop the pending rvalid; no read SHALL be issued until reset_n is high.

Configuration
REQ-027 With macro RD_ARB_STATS_EN defined, SHALL add output rd_count (16 bits): total FIFO reads since reset, saturating at 16'hFFFF, reset to 0.
REQ-028 Without RD_ARB_STATS_EN, rd_count and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-029 Reset, then req=4'b0001 with FIFO holding 6 words, BURST_MAX=4 -> grant=0001, 4 reads, rvalid[0] on 4 consecutive cycles, return to IDLE, regrant 0001, 2 reads, IDLE on empty.
REQ-030 req=4'b1111 held, FIFO non-empty -> grant sequence 0001,0010,0100,1000,0001, each for BURST_MAX reads.
REQ-031 FIFO holds 2 words, req[2] held -> 2 reads, fifo_empty high ends burst, no third rvalid, no fifo_req_read while empty.
REQ-032 req[1] dropped after 1 read -> grant clears next cycle; the rvalid[1] for that read still arrives.
REQ-033 reset_n pulsed low mid-burst -> grant, rvalid and busy 0 immediately; after release, the first grant goes to index 0.
REQ-034 With RD_ARB_STATS_EN defined, 10 reads -> rd_count=10; forcing the counter to 16'hFFFF and then reading -> stays 16'hFFFF.
